// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing for the cache-line to memory-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned CACHE_LINE_WIDTH = 256;
  localparam int unsigned BURST_LEN        = 4;
  localparam int unsigned ADDR_WIDTH       = 32;
  localparam int unsigned TIMEOUT_CYCLES   = 1024;

  localparam int unsigned BEAT_WIDTH  = CACHE_LINE_WIDTH / BURST_LEN;
  localparam int unsigned CNT_WIDTH   = $clog2(BURST_LEN);
  localparam int unsigned OFFSET_BITS = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int unsigned WD_WIDTH    = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Line viewed as an array of memory beats, beat 0 in the low bits.
  typedef logic [BURST_LEN-1:0][BEAT_WIDTH-1:0] line_t;

  function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
  endfunction

endpackage

// File: rtl/cacheline_adaptor_burst_counter.sv
// Up-counter with synchronous clear, increment and terminal-count flag.
module burst_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LAST  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             last_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == WIDTH'(LAST));

endmodule

// File: rtl/cacheline_adaptor.sv
// Turns one cache-line read/write into a BURST_LEN-beat memory burst.
// Optional watchdog abort enabled by CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CACHE_LINE_WIDTH-1:0] line_i,
  output logic [CACHE_LINE_WIDTH-1:0] line_o,
  input  logic [ADDR_WIDTH-1:0]       address_i,
  input  logic                        read_i,
  input  logic                        write_i,
  output logic                        resp_o,
  input  logic [BEAT_WIDTH-1:0]       burst_i,
  output logic [BEAT_WIDTH-1:0]       burst_o,
  output logic [ADDR_WIDTH-1:0]       address_o,
  output logic                        read_o,
  output logic                        write_o,
  input  logic                        resp_i,
  output logic                        err_o
);

  state_e                state_q;
  line_t                 line_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  read_q, write_q, resp_q, err_q;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  cnt_last_c, in_burst_c, beat_c, final_beat_c, timeout_c;

  assign in_burst_c   = (state_q == RD_BURST) || (state_q == WR_BURST);
  assign beat_c       = in_burst_c && resp_i;
  assign final_beat_c = beat_c && cnt_last_c;

  burst_counter #(.WIDTH(CNT_WIDTH), .LAST(BURST_LEN - 1)) u_beat_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!in_burst_c || timeout_c),
    .inc_i  (beat_c),
    .cnt_o  (cnt),
    .last_o (cnt_last_c)
  );

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic [WD_WIDTH-1:0] wd_cnt;
  logic                wd_last_c;

  // Restarts on every beat and whenever no burst is in flight; saturates at the limit.
  burst_counter #(.WIDTH(WD_WIDTH), .LAST(TIMEOUT_CYCLES - 1)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!in_burst_c || resp_i),
    .inc_i  (in_burst_c && !wd_last_c),
    .cnt_o  (wd_cnt),
    .last_o (wd_last_c)
  );

  assign timeout_c = in_burst_c && !resp_i && wd_last_c && (wd_cnt != '0);
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      // A memory beat with no burst outstanding is a protocol violation.
      if (!in_burst_c && resp_i) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (read_i) begin
            addr_q  <= align_addr(address_i);
            read_q  <= 1'b1;
            state_q <= RD_BURST;
          end else if (write_i) begin
            addr_q  <= align_addr(address_i);
            line_q  <= line_i;
            write_q <= 1'b1;
            state_q <= WR_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) line_q[cnt] <= burst_i;
          if (timeout_c) begin
            err_q   <= 1'b1;
            read_q  <= 1'b0;
            state_q <= IDLE;
          end else if (final_beat_c) begin
            read_q  <= 1'b0;
            resp_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        WR_BURST: begin
          if (timeout_c) begin
            err_q   <= 1'b1;
            write_q <= 1'b0;
            state_q <= IDLE;
          end else if (final_beat_c) begin
            write_q <= 1'b0;
            resp_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign line_o    = line_q;
  assign burst_o   = write_q ? line_q[cnt] : '0;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor with a scoreboard of expected lines and beats.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i, err_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [255:0] exp_lines[$];
  logic [63:0]  exp_beats[$];

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish, observed running required done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Cache read with a memory that waits 'delay' request cycles before streaming four beats.
  task automatic do_read(input logic [31:0] a, input int delay, input logic both,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0]  bt[4];
    logic [255:0] exp_line;
    bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    exp_lines.push_back({b3, b2, b1, b0});
    @(negedge clk);
    read_i = 1'b1; write_i = both; address_i = a;
    @(negedge clk);
    for (int i = 1; i <= delay + 4; i++) begin
      chk("rd_req_high", 256'(read_o), 256'(1));
      chk("rd_no_write", 256'(write_o), 256'(0));
      chk("rd_addr", 256'(address_o), 256'(a & 32'hFFFF_FFE0));
      chk("rd_no_early_resp", 256'(resp_o), 256'(0));
      resp_i  = (i > delay);
      burst_i = (i > delay) ? bt[i-delay-1] : 64'h0;
      @(negedge clk);
    end
    resp_i = 1'b0; burst_i = 64'h0;
    chk("rd_req_drop", 256'(read_o), 256'(0));
    chk("rd_resp", 256'(resp_o), 256'(1));
    if (exp_lines.size() > 0) begin
      exp_line = exp_lines.pop_front();
      chk("rd_line", line_o, exp_line);
    end
    read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
    chk("rd_resp_pulse", 256'(resp_o), 256'(0));
    chk("rd_idle_write", 256'(write_o), 256'(0));
  endtask

  // Cache write; the memory side checks each presented beat against the scoreboard.
  task automatic do_write(input logic [31:0] a, input int delay, input logic [255:0] ln);
    logic [255:0] tmp;
    logic [63:0]  exp_beat;
    tmp = ln;
    for (int k = 0; k < 4; k++) exp_beats.push_back(tmp[64*k +: 64]);
    @(negedge clk);
    write_i = 1'b1; line_i = ln; address_i = a;
    @(negedge clk);
    for (int i = 1; i <= delay + 4; i++) begin
      chk("wr_req_high", 256'(write_o), 256'(1));
      chk("wr_no_read", 256'(read_o), 256'(0));
      chk("wr_addr", 256'(address_o), 256'(a & 32'hFFFF_FFE0));
      resp_i = (i > delay);
      if (resp_i && exp_beats.size() > 0) begin
        exp_beat = exp_beats.pop_front();
        chk("wr_beat", 256'(burst_o), 256'(exp_beat));
      end
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("wr_req_drop", 256'(write_o), 256'(0));
    chk("wr_resp", 256'(resp_o), 256'(1));
    write_i = 1'b0;
    @(negedge clk);
    chk("wr_resp_pulse", 256'(resp_o), 256'(0));
  endtask

  initial begin
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    #12;
    chk("rst_read_o", 256'(read_o), 256'(0));
    chk("rst_write_o", 256'(write_o), 256'(0));
    chk("rst_resp_o", 256'(resp_o), 256'(0));
    chk("rst_err_o", 256'(err_o), 256'(0));
    chk("rst_line_o", line_o, 256'(0));
    chk("rst_burst_o", 256'(burst_o), 256'(0));
    chk("rst_address_o", 256'(address_o), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    do_read(32'h0000_0064, 5, 1'b0,
            64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);

    do_write(32'h0000_1234, 3,
             256'hDEADBEEF_01234567_89ABCDEF_CAFEF00D_0BADC0DE_13579BDF_2468ACE0_FEEDBEEF);

    do_read(32'hABCD_EF9F, 2, 1'b1,
            64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
            64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0);

    do_read(32'h0000_0040, 0, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE);

    // Reset in the middle of a read burst, after two beats.
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h0000_0F00;
    @(negedge clk);
    resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    @(negedge clk);
    resp_i = 1'b0; burst_i = '0;
    chk("mid_read_active", 256'(read_o), 256'(1));
    rst = 1'b1;
    #1;
    chk("async_rst_read_o", 256'(read_o), 256'(0));
    chk("async_rst_line_o", line_o, 256'(0));
    chk("async_rst_address_o", 256'(address_o), 256'(0));
    chk("async_rst_resp_o", 256'(resp_o), 256'(0));
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h0000_0F10, 1, 1'b0,
            64'hC0C0_C0C0_C0C0_C0C0, 64'hC1C1_C1C1_C1C1_C1C1,
            64'hC2C2_C2C2_C2C2_C2C2, 64'hC3C3_C3C3_C3C3_C3C3);
    chk("no_err_before_stray", 256'(err_o), 256'(0));

    // Stray memory beat while idle.
    @(negedge clk);
    resp_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b0;
    chk("stray_err_set", 256'(err_o), 256'(1));
    chk("stray_no_read", 256'(read_o), 256'(0));
    chk("stray_no_resp", 256'(resp_o), 256'(0));
    repeat (3) @(negedge clk);
    chk("stray_err_sticky", 256'(err_o), 256'(1));
    do_write(32'h0000_2000, 0,
             256'h00000000_11111111_22222222_33333333_44444444_55555555_66666666_77777777);
    chk("err_sticky_after_write", 256'(err_o), 256'(1));
    rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", 256'(err_o), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits between the last-level cache and physical memory.
- Converts one full cache-line request (read or write, 256 bits) into a single burst transaction on the memory port. The burst is BURST_LEN beats of 64 bits.
- Read beats are assembled into a line. Write lines are serialised into beats.
- Cache side sees a single-cycle completion pulse (resp_o).

Parameters:
- CACHE_LINE_WIDTH, 256, line width in bits; must be a multiple of BURST_LEN.
- BURST_LEN, 4, beats per burst.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- line_i  in  CACHE_LINE_WIDTH  write line from cache.
- line_o  out  CACHE_LINE_WIDTH  read line to cache; valid while resp_o=1.
- address_i  in  ADDR_WIDTH  cache request address.
- read_i  in  1  cache read request; level, held until resp_o.
- write_i  in  1  cache write request; level, held until resp_o.
- resp_o  out  1  one-cycle completion pulse.
- burst_i  in  CACHE_LINE_WIDTH/BURST_LEN  read beat from memory.
- burst_o  out  CACHE_LINE_WIDTH/BURST_LEN  write beat to memory.
- address_o  out  ADDR_WIDTH  memory address, line-aligned.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  memory beat strobe.
- err_o  out  1  sticky protocol/timeout error.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, beat counter=0, line register=0, address register=0. All outputs 0: resp_o, read_o, write_o, err_o, burst_o, line_o.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - read_i=1: latch address_i with its low log2(CACHE_LINE_WIDTH/8) bits cleared, go to RD_BURST.
  - write_i=1 (and read_i=0): latch address_i (aligned) and line_i, go to WR_BURST.
  - read_i and write_i both 1: read wins; write_i is ignored for this transaction.
- RD_BURST:
  - read_o=1; address_o holds the latched address.
  - On each edge with resp_i=1: store burst_i into line slice [W*cnt +: W] (W = beat width) and increment cnt.
  - When the edge with cnt==BURST_LEN-1 and resp_i=1 occurs, go to DONE.
- WR_BURST:
  - write_o=1; address_o holds the latched address.
  - burst_o = line[W*cnt +: W] combinationally, so beat i is presented during the cycle memory drives resp_i for beat i.
  - Increment cnt on each resp_i edge; the final beat goes to DONE.
- Memory protocol rules:
  - read_o/write_o and address_o are stable from the first request cycle through the cycle of the last resp_i beat.
  - Never both high.
  - Deasserted in the cycle following the last beat.
- DONE:
  - resp_o=1 for exactly one cycle; line_o = assembled line (reads).
  - read_o=write_o=0; cnt cleared; next state IDLE.
- A cache request still high in the IDLE cycle after DONE starts a new transaction. The cache must drop the request on the resp_o cycle to avoid this.
- Latency: read = memory delay + BURST_LEN + 1 cycles from request to resp_o.
- resp_i while in IDLE or DONE: ignored, and err_o is set (sticky until rst).
- The beat counter is log2(BURST_LEN) bits wide and wraps to 0 on entering DONE.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on each resp_i and on entry to RD_BURST/WR_BURST.
  - If it reaches TIMEOUT_CYCLES while in RD_BURST/WR_BURST, err_o is set and the FSM aborts to IDLE with no resp_o.
  - Memory request lines drop the next cycle.
- Undefined: no watchdog; the only source of err_o is a stray resp_i.

Decomposition:
- Package cacheline_adaptor_pkg:
  - state enum (IDLE, RD_BURST, WR_BURST, DONE);
  - localparams BEAT_WIDTH, CNT_WIDTH, OFFSET_BITS;
  - address-align function.
- Sub-module burst_counter: CNT_WIDTH-bit up-counter with clear, increment and last-beat flag. Reused by the watchdog (parameterised width).

Test Plan:
- Read, memory delay 5: read_i=1 at address 0x0000_0064, burst_i = 0x11.., 0x22.., 0x33.., 0x44.. → address_o=0x0000_0060; read_o high for 9 cycles; resp_o pulses once; line_o = {0x44..,0x33..,0x22..,0x11..}.
- Write, delay 3: write_i=1, line_i = 256'hDEAD..BEEF → burst_o = line[63:0], then [127:64], [191:128], [255:192] on successive resp_i cycles; write_o drops the cycle after beat 4; memory line matches.
- Simultaneous read_i=write_i=1 → only read_o asserts; write_o stays 0 throughout.
- rst asserted mid-RD_BURST after 2 beats → all outputs 0 immediately (asynchronous). The next read completes correctly with cnt restarting at 0.
- resp_i pulsed in IDLE → err_o=1 and stays 1 until rst; no state change.
- CACHELINE_ADAPTOR_TIMEOUT_EN with TIMEOUT_CYCLES=16 and memory never responding → err_o=1 at cycle 16; read_o=0 the cycle after; resp_o never asserts.
